// File: rtl/dec_fp_pkg.sv
// Shared types and constants for the decimal FP normalisation datapath.
package dec_fp_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  // Bit positions inside the {ovf,unf,inx} flag vector
  localparam int FLG_INX = 0;
  localparam int FLG_UNF = 1;
  localparam int FLG_OVF = 2;

  localparam logic [7:0] EXP_OVF_DEF = 8'hC0;
  localparam bcd_digit_t BCD_NINE    = 4'h9;

endpackage

// File: rtl/dec_normalize_pipe_if.sv
// Handshake and data bundle for dec_normalize_pipe: master is the environment, slave the stage.
interface dec_normalize_pipe_if
  import dec_fp_pkg::*;
#(
  parameter int DIGITS = 7,
  parameter int EXP_W  = 8
);

  logic                      in_valid;
  logic                      in_ready;
  logic [DIGIT_W*DIGITS-1:0] in_mr;
  logic [EXP_W-1:0]          in_er;
  logic [DIGIT_W-1:0]        in_carry;
  logic                      out_valid;
  logic                      out_ready;
  logic [DIGIT_W*DIGITS-1:0] out_mr;
  logic [EXP_W-1:0]          out_er;
  logic                      out_ovf;
  logic                      out_unf;
  logic                      out_inx;
  logic                      flag_clr;
  logic [2:0]                sticky;

  modport master (
    output in_valid, in_mr, in_er, in_carry, out_ready, flag_clr,
    input  in_ready, out_valid, out_mr, out_er, out_ovf, out_unf, out_inx, sticky
  );

  modport slave (
    input  in_valid, in_mr, in_er, in_carry, out_ready, flag_clr,
    output in_ready, out_valid, out_mr, out_er, out_ovf, out_unf, out_inx, sticky
  );

endinterface

// File: rtl/dec_lzd_count.sv
// Combinational count of leading zero BCD digits (0..DIGITS) of a mantissa.
module dec_lzd_count
  import dec_fp_pkg::*;
#(
  parameter  int DIGITS = 7,
  localparam int CW     = $clog2(DIGITS + 1)
) (
  input  logic [DIGIT_W*DIGITS-1:0] mr,
  output logic [CW-1:0]             lzd
);

  logic [DIGITS-1:0] digit_zero;
  logic              found;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dz
      assign digit_zero[gi] = (mr[DIGIT_W*gi +: DIGIT_W] == '0);
    end
  endgenerate

  // Scan from the most significant digit; stop counting at the first nonzero digit
  always_comb begin
    lzd   = '0;
    found = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (!found && digit_zero[i]) begin
        lzd = lzd + CW'(1);
      end else begin
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dec_normalize_pipe.sv
// Two-stage BCD normalisation: S1 absorbs the carry digit and counts leading zeros,
// S2 left-normalises and raises ovf/unf/inx. Define DEC_NORM_SAT_EN to saturate on overflow.
module dec_normalize_pipe
  import dec_fp_pkg::*;
#(
  parameter int               DIGITS  = 7,
  parameter int               EXP_W   = 8,
  parameter logic [EXP_W-1:0] EXP_OVF = EXP_W'(EXP_OVF_DEF),
  parameter logic [EXP_W-1:0] EXP_MIN = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dec_normalize_pipe_if.slave  bus
);

  localparam int MW = DIGIT_W * DIGITS;
  localparam int LW = $clog2(DIGITS + 1);

  logic s1_valid_reg, s2_valid_reg;
  logic s1_advance, s2_advance;

  assign s2_advance = !s2_valid_reg || bus.out_ready;
  assign s1_advance = !s1_valid_reg || s2_advance;
  assign bus.in_ready = s1_advance;

  // ---------------- S1: carry handling + leading-zero count ----------------
  logic             carry_in;
  logic [EXP_W:0]   er_inc;
  logic [MW-1:0]    s1_mr_next;
  logic [EXP_W-1:0] s1_er_next;
  logic             s1_wrap_next, s1_inx_next;
  logic [LW-1:0]    s1_lzd_next;

  // Any nonzero carry digit is treated as a carry of one
  assign carry_in     = (bus.in_carry != '0);
  assign er_inc       = {1'b0, bus.in_er} + {{EXP_W{1'b0}}, 1'b1};
  assign s1_mr_next   = carry_in ? {DIGIT_W'(1), bus.in_mr[MW-1:DIGIT_W]} : bus.in_mr;
  assign s1_er_next   = carry_in ? er_inc[EXP_W-1:0] : bus.in_er;
  assign s1_wrap_next = carry_in && er_inc[EXP_W];
  assign s1_inx_next  = carry_in && (bus.in_mr[DIGIT_W-1:0] != '0);

  dec_lzd_count #(.DIGITS(DIGITS)) u_lzd (
    .mr  (s1_mr_next),
    .lzd (s1_lzd_next)
  );

  logic [MW-1:0]    s1_mr_reg;
  logic [EXP_W-1:0] s1_er_reg;
  logic             s1_wrap_reg, s1_inx_reg;
  logic [LW-1:0]    s1_lzd_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_mr_reg    <= '0;
      s1_er_reg    <= '0;
      s1_wrap_reg  <= 1'b0;
      s1_inx_reg   <= 1'b0;
      s1_lzd_reg   <= '0;
    end else if (s1_advance) begin
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        s1_mr_reg   <= s1_mr_next;
        s1_er_reg   <= s1_er_next;
        s1_wrap_reg <= s1_wrap_next;
        s1_inx_reg  <= s1_inx_next;
        s1_lzd_reg  <= s1_lzd_next;
      end
    end
  end

  // ---------------- S2: normalise and flag ----------------
  logic [EXP_W-1:0] room, lzd_ext, sh, norm_er;
  logic [MW-1:0]    norm_mr;
  logic             is_zero, clip;
  logic [MW-1:0]    s2_mr_next;
  logic [EXP_W-1:0] s2_er_next;
  logic             s2_ovf_next, s2_unf_next, s2_inx_next;

  assign room    = s1_er_reg - EXP_MIN;
  assign lzd_ext = EXP_W'(s1_lzd_reg);
  assign is_zero = (s1_lzd_reg == LW'(DIGITS));
  // Shift is limited by exponent headroom; hitting that limit yields a subnormal
  assign clip    = (lzd_ext > room);
  assign sh      = clip ? room : lzd_ext;
  assign norm_mr = s1_mr_reg << {sh, 2'b00};
  assign norm_er = s1_er_reg - sh;

  always_comb begin
    s2_mr_next  = norm_mr;
    s2_er_next  = norm_er;
    s2_ovf_next = (norm_er >= EXP_OVF) || s1_wrap_reg;
    s2_unf_next = clip;
    s2_inx_next = s1_inx_reg || s2_ovf_next;
    if (is_zero) begin
      s2_mr_next  = '0;
      s2_er_next  = EXP_MIN;
      s2_ovf_next = 1'b0;
      s2_unf_next = 1'b0;
      s2_inx_next = 1'b0;
    end
`ifdef DEC_NORM_SAT_EN
    if (s2_ovf_next) begin
      s2_er_next = '1;
      s2_mr_next = {DIGITS{BCD_NINE}};
    end
`endif
  end

  logic [MW-1:0]    s2_mr_reg;
  logic [EXP_W-1:0] s2_er_reg;
  logic [2:0]       s2_flags_reg;
  logic [2:0]       sticky_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      s2_mr_reg    <= '0;
      s2_er_reg    <= '0;
      s2_flags_reg <= '0;
    end else if (s2_advance) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_mr_reg             <= s2_mr_next;
        s2_er_reg             <= s2_er_next;
        s2_flags_reg[FLG_OVF] <= s2_ovf_next;
        s2_flags_reg[FLG_UNF] <= s2_unf_next;
        s2_flags_reg[FLG_INX] <= s2_inx_next;
      end
    end
  end

  // A clear in the same cycle as a handshake drops that beat's flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_reg <= '0;
    end else if (bus.flag_clr) begin
      sticky_reg <= '0;
    end else if (s2_valid_reg && bus.out_ready) begin
      sticky_reg <= sticky_reg | s2_flags_reg;
    end
  end

  assign bus.out_valid = s2_valid_reg;
  assign bus.out_mr    = s2_mr_reg;
  assign bus.out_er    = s2_er_reg;
  assign bus.out_ovf   = s2_flags_reg[FLG_OVF];
  assign bus.out_unf   = s2_flags_reg[FLG_UNF];
  assign bus.out_inx   = s2_flags_reg[FLG_INX];
  assign bus.sticky    = sticky_reg;

endmodule

// File: tb/tb_dec_normalize_pipe.sv
// Scoreboard bench for dec_normalize_pipe: driver pushes expected results, monitor pops on handshake.
module tb_dec_normalize_pipe;
  import dec_fp_pkg::*;

  localparam int DIGITS = 7;
  localparam int EXP_W  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dec_normalize_pipe_if #(.DIGITS(DIGITS), .EXP_W(EXP_W)) bus ();

  dec_normalize_pipe #(.DIGITS(DIGITS), .EXP_W(EXP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [27:0] mr;
    logic [7:0]  er;
    logic        ovf;
    logic        unf;
    logic        inx;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic exp_t mk(input logic [27:0] mr, input logic [7:0] er,
                              input logic ovf, input logic unf, input logic inx);
    exp_t e;
    e.mr = mr; e.er = er; e.ovf = ovf; e.unf = unf; e.inx = inx;
`ifdef DEC_NORM_SAT_EN
    if (ovf) begin
      e.mr = 28'h9999999;
      e.er = 8'hFF;
    end
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Carry digit must be 0 or 1 whenever a beat is offered
  always @(posedge clk) begin
    if (rst_n && bus.in_valid) begin
      assert (bus.in_carry <= 4'd1) else $error("illegal carry digit %h", bus.in_carry);
    end
  end

  // Monitor: sample just before each rising edge
  initial begin : monitor
    exp_t got, prev, e;
    logic stalled;
    stalled = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        got.mr = bus.out_mr; got.er = bus.out_er;
        got.ovf = bus.out_ovf; got.unf = bus.out_unf; got.inx = bus.out_inx;
        if (bus.out_valid && stalled) chk("hold_stable", 64'(got), 64'(prev));
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            chk("spurious_output", 64'(1), 64'(0));
          end else begin
            e = sb.pop_front();
            $display("OUT mr=%h er=%h ovf=%b unf=%b inx=%b", got.mr, got.er, got.ovf, got.unf, got.inx);
            chk("result", 64'(got), 64'(e));
          end
          stalled = 1'b0;
        end else if (bus.out_valid) begin
          stalled = 1'b1;
          prev = got;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [27:0] mr, input logic [7:0] er, input logic [3:0] c, input exp_t e);
    int g;
    g = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_mr    = mr;
    bus.in_er    = er;
    bus.in_carry = c;
    #1;
    while (!bus.in_ready && g < 50) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 64'(0), 64'(1));
      bus.in_valid = 1'b0;
    end else begin
      sb.push_back(e);
      $display("IN  mr=%h er=%h carry=%h", mr, er, c);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("drain_empty", 64'(sb.size()), 64'(0));
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int g;
    bus.in_valid = 1'b0; bus.in_mr = '0; bus.in_er = '0; bus.in_carry = '0;
    bus.out_ready = 1'b1; bus.flag_clr = 1'b0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_mr", 64'(bus.out_mr), 64'(0));
    chk("rst_out_er", 64'(bus.out_er), 64'(0));
    chk("rst_out_flags", 64'({bus.out_ovf, bus.out_unf, bus.out_inx}), 64'(0));
    chk("rst_sticky", 64'(bus.sticky), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));

    // Carry shift, with latency check
    send(28'h0234567, 8'h40, 4'h1, mk(28'h1023456, 8'h41, 1'b0, 1'b0, 1'b1));
    chk("lat_early", 64'(bus.out_valid), 64'(0));
    @(posedge clk); #1;
    chk("lat_valid", 64'(bus.out_valid), 64'(1));
    drain();
    chk("sticky_inx", 64'(bus.sticky), 64'(3'b001));

    // Leading-zero normalisation, underflow, boundaries
    send(28'h0001234, 8'h40, 4'h0, mk(28'h1234000, 8'h3D, 1'b0, 1'b0, 1'b0));
    send(28'h0000012, 8'h02, 4'h0, mk(28'h0001200, 8'h00, 1'b0, 1'b1, 1'b0));
    drain();
    chk("sticky_unf", 64'(bus.sticky), 64'(3'b011));
    send(28'h0000123, 8'h03, 4'h0, mk(28'h0123000, 8'h00, 1'b0, 1'b1, 1'b0));
    send(28'h0001234, 8'h03, 4'h0, mk(28'h1234000, 8'h00, 1'b0, 1'b0, 1'b0));
    send(28'h1234567, 8'h10, 4'h0, mk(28'h1234567, 8'h10, 1'b0, 1'b0, 1'b0));
    send(28'h1234560, 8'hBE, 4'h1, mk(28'h1123456, 8'hBF, 1'b0, 1'b0, 1'b0));
    drain();
    chk("sticky_no_ovf", 64'(bus.sticky), 64'(3'b011));

    // Overflow at threshold and exponent wrap
    send(28'h9999999, 8'hBF, 4'h1, mk(28'h1999999, 8'hC0, 1'b1, 1'b0, 1'b1));
    send(28'h0000005, 8'hFF, 4'h1, mk(28'h1000000, 8'h00, 1'b1, 1'b0, 1'b1));
    drain();
    chk("sticky_all", 64'(bus.sticky), 64'(3'b111));

    // Zero result with downstream stall and back-to-back input
    bus.out_ready = 1'b0;
    fork
      begin
        send(28'h0000000, 8'h55, 4'h0, mk(28'h0000000, 8'h00, 1'b0, 1'b0, 1'b0));
        send(28'h0001234, 8'h40, 4'h0, mk(28'h1234000, 8'h3D, 1'b0, 1'b0, 1'b0));
        send(28'h0000012, 8'h02, 4'h0, mk(28'h0001200, 8'h00, 1'b0, 1'b1, 1'b0));
      end
      begin
        repeat (3) @(negedge clk);
        #2;
        chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
        chk("stall_out_valid", 64'(bus.out_valid), 64'(1));
        chk("stall_zero_mr", 64'(bus.out_mr), 64'(0));
        chk("stall_zero_er", 64'(bus.out_er), 64'(0));
        repeat (2) @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // flag_clr concurrent with an overflow handshake
    bus.out_ready = 1'b0;
    send(28'h9999999, 8'hBF, 4'h1, mk(28'h1999999, 8'hC0, 1'b1, 1'b0, 1'b1));
    g = 0;
    while (!bus.out_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("clr_out_valid", 64'(bus.out_valid), 64'(1));
    bus.flag_clr  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.flag_clr = 1'b0;
    #1;
    chk("clr_sticky", 64'(bus.sticky), 64'(0));
    chk("clr_queue", 64'(sb.size()), 64'(0));

    // Asynchronous reset with a beat in flight
    send(28'h0234567, 8'h40, 4'h1, mk(28'h1023456, 8'h41, 1'b0, 1'b0, 1'b1));
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("rst_mid_valid", 64'(bus.out_valid), 64'(0));
    @(posedge clk); #1;
    chk("rst_hold_valid", 64'(bus.out_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rel_ready", 64'(bus.in_ready), 64'(1));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_idle_valid", 64'(bus.out_valid), 64'(0));
    end

    send(28'h0001234, 8'h40, 4'h0, mk(28'h1234000, 8'h3D, 1'b0, 1'b0, 1'b0));
    drain();
    chk("final_sticky", 64'(bus.sticky), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
